// File: rtl/keypad_debouncer.sv
// keypad_debouncer: multi-channel column debouncer
// sync -> tick-gated stability counter -> level, strobes, key code
module keypad_debouncer #(
  parameter int N_COLS        = 3,
  parameter int STABLE_CYCLES = 4,
  parameter int TICK_DIV      = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_COLS-1:0] column,
  output logic [N_COLS-1:0] key_state,
  output logic [N_COLS-1:0] key_press,
  output logic [N_COLS-1:0] key_release,
  output logic              any_key_down,
  output logic [((N_COLS > 1) ? $clog2(N_COLS) : 1)-1:0] key_code
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int KW = (N_COLS > 1) ? $clog2(N_COLS) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [PW-1:0] DIV_LAST = PW'(TICK_DIV - 1);

  logic [N_COLS-1:0] sync1;
  logic [N_COLS-1:0] sync2;
  logic [N_COLS-1:0] raw;
  logic [PW-1:0]     pcnt;
  logic              tick;
  logic [CW-1:0]     cnt_q [N_COLS];
  logic [CW-1:0]     cnt_d [N_COLS];
  logic [N_COLS-1:0] flip;

  // two-flop synchroniser on the raw active-low lines
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= column;
      sync2 <= sync1;
    end
  end

  assign raw  = ~sync2;
  assign tick = (pcnt == DIV_LAST);

  // sample-tick prescaler, wraps at TICK_DIV-1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // per-channel stability counting; agreeing sample cancels
  always_comb begin
    flip = '0;
    for (int i = 0; i < N_COLS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick) begin
        if (raw[i] == key_state[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          cnt_d[i] = '0;
          flip[i]  = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // counters, debounced level and edge strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_COLS; i++) begin
        cnt_q[i] <= '0;
      end
      key_state   <= '0;
      key_press   <= '0;
      key_release <= '0;
    end else begin
      for (int i = 0; i < N_COLS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      key_state   <= key_state ^ flip;
      key_press   <= flip & ~key_state;
      key_release <= flip & key_state;
    end
  end

  // summary flag and lowest-index priority encode
  always_comb begin
    any_key_down = |key_state;
    key_code     = '0;
    for (int i = N_COLS - 1; i >= 0; i--) begin
      if (key_state[i]) begin
        key_code = KW'(i);
      end
    end
  end

endmodule

// File: tb/tb_keypad_debouncer.sv
// tb_keypad_debouncer: random + directed checks of two
// debouncer configurations against a run-length model
module tb_keypad_debouncer;

  typedef struct {
    logic [2:0] q0;
    logic [2:0] q1;
    logic [2:0] st;
    logic [2:0] pr;
    logic [2:0] rl;
    int         cyc;
    int         run [3];
  } mstate_t;

  logic       clk;
  logic       reset;
  logic [2:0] column;

  logic [2:0] ks0, kp0, kr0;
  logic       any0;
  logic [1:0] code0;
  logic [2:0] ks1, kp1, kr1;
  logic       any1;
  logic [1:0] code1;

  int checks;
  int failures;
  bit started;

  mstate_t ms0;
  mstate_t ms1;

  keypad_debouncer #(
    .N_COLS(3), .STABLE_CYCLES(4), .TICK_DIV(1)
  ) dut0 (
    .clk(clk), .reset(reset), .column(column),
    .key_state(ks0), .key_press(kp0),
    .key_release(kr0), .any_key_down(any0),
    .key_code(code0)
  );

  keypad_debouncer #(
    .N_COLS(3), .STABLE_CYCLES(2), .TICK_DIV(4)
  ) dut1 (
    .clk(clk), .reset(reset), .column(column),
    .key_state(ks1), .key_press(kp1),
    .key_release(kr1), .any_key_down(any1),
    .key_code(code1)
  );

  always #5 clk = ~clk;

  function automatic mstate_t init_state();
    mstate_t s;
    s.q0  = '1;
    s.q1  = '1;
    s.st  = '0;
    s.pr  = '0;
    s.rl  = '0;
    s.cyc = 0;
    for (int i = 0; i < 3; i++) s.run[i] = 0;
    return s;
  endfunction

  // a channel flips once it has seen sc differing ticks in a row
  function automatic mstate_t step(mstate_t s, logic [2:0] col,
                                   int sc, int td);
    mstate_t    n;
    logic [2:0] pressed;
    bit         tk;
    n       = s;
    pressed = ~s.q1;
    tk      = ((s.cyc % td) == td - 1);
    n.pr    = '0;
    n.rl    = '0;
    for (int i = 0; i < 3; i++) begin
      if (tk) begin
        if (pressed[i] == s.st[i]) begin
          n.run[i] = 0;
        end else begin
          n.run[i] = s.run[i] + 1;
          if (n.run[i] == sc) begin
            n.st[i]  = ~s.st[i];
            n.run[i] = 0;
            if (pressed[i]) n.pr[i] = 1'b1;
            else            n.rl[i] = 1'b1;
          end
        end
      end
    end
    n.q1  = s.q0;
    n.q0  = col;
    n.cyc = s.cyc + 1;
    return n;
  endfunction

  function automatic logic [1:0] low_code(logic [2:0] v);
    if (v[0]) return 2'd0;
    if (v[1]) return 2'd1;
    if (v[2]) return 2'd2;
    return 2'd0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ms0 <= init_state();
      ms1 <= init_state();
    end else begin
      ms0 <= step(ms0, column, 4, 1);
      ms1 <= step(ms1, column, 2, 4);
    end
  end

  task automatic check_dut(string nm, logic [2:0] ks,
                           logic [2:0] kp, logic [2:0] kr,
                           logic an, logic [1:0] cd, mstate_t s);
    logic [10:0] act;
    logic [10:0] exp;
    act = {ks, kp, kr, an, cd};
    exp = {s.st, s.pr, s.rl, |s.st, low_code(s.st)};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got ks/kp/kr/any/code=%b want %b",
               nm, $time, act, exp);
    end
  endtask

  task automatic lit(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got %0h want %0h",
               nm, $time, act, exp);
    end
  endtask

  // per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (started) begin
      check_dut("model_dut0", ks0, kp0, kr0, any0, code0, ms0);
      check_dut("model_dut1", ks1, kp1, kr1, any1, code1, ms1);
    end
  end

  initial begin
    logic bad;
    int   n;
    clk      = 1'b0;
    reset    = 1'b0;
    column   = 3'b110;
    checks   = 0;
    failures = 0;
    started  = 1'b0;

    @(posedge clk);
    started = 1'b1;
    repeat (3) @(negedge clk);
    lit("reset_ks0", {29'd0, ks0}, 32'd0);
    lit("reset_strobes0", {26'd0, kp0, kr0}, 32'd0);
    lit("reset_ks1", {29'd0, ks1}, 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    lit("t1_edge5_ks", {29'd0, ks0}, 32'd0);
    @(negedge clk);
    lit("t1_edge6_ks", {29'd0, ks0}, 32'h1);
    lit("t1_edge6_kp", {29'd0, kp0}, 32'h1);
    @(negedge clk);
    lit("t1_kp_drop", {29'd0, kp0}, 32'd0);

    column = 3'b111;
    repeat (10) @(negedge clk);
    bad = 1'b0;
    column = 3'b101;
    repeat (3) begin
      @(negedge clk);
      bad |= ks0[1] | kp0[1] | kr0[1];
    end
    column = 3'b111;
    @(negedge clk);
    bad |= ks0[1] | kp0[1] | kr0[1];
    column = 3'b101;
    repeat (3) begin
      @(negedge clk);
      bad |= ks0[1] | kp0[1] | kr0[1];
    end
    column = 3'b111;
    repeat (8) begin
      @(negedge clk);
      bad |= ks0[1] | kp0[1] | kr0[1];
    end
    lit("t2_bounce_reject", {31'd0, bad}, 32'd0);

    column = 3'b011;
    repeat (5) @(negedge clk);
    lit("t3_press_edge5", {31'd0, ks0[2]}, 32'd0);
    @(negedge clk);
    lit("t3_press_edge6", {30'd0, ks0[2], kp0[2]}, 32'h3);
    @(negedge clk);
    lit("t3_press_once", {29'd0, kp0}, 32'd0);
    repeat (5) @(negedge clk);
    column = 3'b111;
    repeat (5) @(negedge clk);
    lit("t3_rel_edge5", {31'd0, ks0[2]}, 32'h1);
    @(negedge clk);
    lit("t3_rel_edge6", {30'd0, ks0[2], kr0[2]}, 32'h1);
    @(negedge clk);
    lit("t3_rel_once", {29'd0, kr0}, 32'd0);
    repeat (4) @(negedge clk);

    column = 3'b010;
    repeat (6) @(negedge clk);
    lit("t4_ks", {29'd0, ks0}, 32'h5);
    lit("t4_kp", {29'd0, kp0}, 32'h5);
    lit("t4_code_any", {29'd0, any0, code0}, 32'h4);
    column = 3'b011;
    repeat (6) @(negedge clk);
    lit("t4_rel_code", {30'd0, code0}, 32'h2);
    lit("t4_rel_kr", {29'd0, kr0}, 32'h1);
    column = 3'b111;
    repeat (20) @(negedge clk);

    bad = 1'b0;
    column = 3'b110;
    repeat (3) begin
      @(negedge clk);
      bad |= ks1[0] | kp1[0];
    end
    column = 3'b111;
    repeat (15) begin
      @(negedge clk);
      bad |= ks1[0] | kp1[0];
    end
    lit("t5_glitch_ignored", {31'd0, bad}, 32'd0);
    column = 3'b110;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ks1[0]) begin
        n = i;
        break;
      end
    end
    lit("t5_latency_ok", {31'd0, (n >= 7 && n <= 10)}, 32'h1);
    lit("t5_kp_high", {31'd0, kp1[0]}, 32'h1);
    @(negedge clk);
    lit("t5_kp_1clk", {31'd0, kp1[0]}, 32'd0);
    repeat (3) @(negedge clk);

    for (int c = 0; c < 1500; ) begin
      int h;
      column = 3'($urandom);
      if ($urandom_range(0, 3) == 0) h = $urandom_range(1, 3);
      else h = $urandom_range(4, 14);
      repeat (h) @(negedge clk);
      c += h;
    end

    column = 3'b101;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ks0 == 3'b010) begin
        n = 1;
        break;
      end
    end
    lit("t6_reach_010", n, 32'h1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    lit("t6_async_ks0", {29'd0, ks0}, 32'd0);
    lit("t6_async_kr0", {26'd0, kr0, kp0}, 32'd0);
    lit("t6_async_ks1", {29'd0, ks1}, 32'd0);
    repeat (2) @(negedge clk);
    lit("t6_no_release", {29'd0, kr0}, 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    lit("t6_edge5", {29'd0, ks0}, 32'd0);
    @(negedge clk);
    lit("t6_edge6_ks", {29'd0, ks0}, 32'h2);
    lit("t6_edge6_kp", {29'd0, kp0}, 32'h2);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
